// File: rtl/pin_access_pkg.sv
// pin_access_pkg: shared types and constants for the pin access engine.
//   state_e      - host-transaction FSM states
//   *_BIT / MSB  - field positions inside the host address byte
//   MAX_BANKS    - largest supported number of 8-pin banks
package pin_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_ACT    = 3'd1,
    ST_WR_COMMIT = 3'd2,
    ST_RD_ACT    = 3'd3,
    ST_RD_DONE   = 3'd4
  } state_e;

  localparam int unsigned OEA_BIT     = 7;
  localparam int unsigned AUTOINC_BIT = 6;
  localparam int unsigned SEL_BIT     = 4;
  localparam int unsigned ADDR_MSB    = 3;
  localparam int unsigned MAX_BANKS   = 16;

endpackage

// File: rtl/strobe_sync.sv
// strobe_sync: multi-flop synchroniser for one asynchronous strobe, plus
// single-cycle rise/fall pulses derived from the synchronised copy.
//   clk, rst  - clock, asynchronous active-high reset
//   async_i   - asynchronous input
//   sync_o    - synchronised level (registered)
//   rise_c    - one-cycle pulse on a synchronised 0->1 transition
//   fall_c    - one-cycle pulse on a synchronised 1->0 transition
module strobe_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] chain_q, chain_d;
  logic              prev_q, prev_d;

  // Shift chain; prev holds the last synced value for edge detection
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], async_i};
    prev_d  = chain_q[STAGES-1];
  end

  // Reset to the idle level so no edge is seen coming out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= {STAGES{RST_VAL}};
      prev_q  <= RST_VAL;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_c = chain_q[STAGES-1] & ~prev_q;
  assign fall_c = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/pin_access_engine.sv
// pin_access_engine: host-strobe driven access to NUM_BANKS x 8 pad output and
// output-enable registers, with snapshotted pin reads.
//   IFCLK, RST        - clock, asynchronous active-high reset
//   nRD, nWR, nD_A    - asynchronous host strobes / address-data select
//   D_I, D_O, D_OE    - host data in, read data out, read drive enable
//   RDY               - high while idle and ready for a new strobe
//   PINS_I            - pad input values (asynchronous)
//   PINS_O, PINS_OE   - registered pad output values and drive enables
module pin_access_engine
  import pin_access_pkg::*;
#(
  parameter int unsigned NUM_BANKS   = 16,
  parameter bit          SEL_ID      = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   IFCLK,
  input  logic                   RST,
  input  logic                   nRD,
  input  logic                   nWR,
  input  logic                   nD_A,
  input  logic [7:0]             D_I,
  output logic [7:0]             D_O,
  output logic                   D_OE,
  output logic                   RDY,
  input  logic [8*NUM_BANKS-1:0] PINS_I,
  output logic [8*NUM_BANKS-1:0] PINS_O,
  output logic [8*NUM_BANKS-1:0] PINS_OE
);

  localparam int unsigned PIN_W = 8 * NUM_BANKS;
  localparam logic [ADDR_MSB:0] LAST_BANK = (ADDR_MSB+1)'(NUM_BANKS - 1);

  if (NUM_BANKS < 1 || NUM_BANKS > MAX_BANKS || SYNC_STAGES < 2) begin : g_bad_params
    $error("pin_access_engine: unsupported NUM_BANKS or SYNC_STAGES");
  end

  // Strobe synchronisers
  logic rd_sync, rd_rise_c, rd_fall_c;
  logic wr_sync, wr_rise_c, wr_fall_c;
  logic da_sync, da_rise_c, da_fall_c;

  strobe_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_rd_sync (
    .clk(IFCLK), .rst(RST), .async_i(nRD),
    .sync_o(rd_sync), .rise_c(rd_rise_c), .fall_c(rd_fall_c));
  strobe_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_wr_sync (
    .clk(IFCLK), .rst(RST), .async_i(nWR),
    .sync_o(wr_sync), .rise_c(wr_rise_c), .fall_c(wr_fall_c));
  strobe_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_da_sync (
    .clk(IFCLK), .rst(RST), .async_i(nD_A),
    .sync_o(da_sync), .rise_c(da_rise_c), .fall_c(da_fall_c));

  logic unused_sync_bits;
  assign unused_sync_bits = rd_sync ^ wr_sync ^ da_rise_c ^ da_fall_c;

  // State
  state_e                  state_q, state_d;
  logic                    is_addr_q, is_addr_d;
  logic [ADDR_MSB:0]       addr_q, addr_d;
  logic                    oea_q, oea_d;
  logic                    autoinc_q, autoinc_d;
  logic                    sel_q, sel_d;
  logic [PIN_W-1:0]        out_q, out_d;
  logic [PIN_W-1:0]        oe_q, oe_d;
  logic [7:0]              d_o_q, d_o_d;
  logic                    d_oe_q, d_oe_d;
  logic                    rdy_q, rdy_d;
  logic [SYNC_STAGES-1:0][PIN_W-1:0] pin_sync_q, pin_sync_d;

  logic [ADDR_MSB:0]       addr_inc;
  logic [7:0]              rd_byte;
  logic                    sel_hit;

  // Pin-input synchroniser chain
  always_comb begin
    pin_sync_d[0] = PINS_I;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      pin_sync_d[i] = pin_sync_q[i-1];
    end
  end

  // Address helpers; out-of-range addresses read as zero and wrap to bank 0
  always_comb begin
    sel_hit  = (sel_q == SEL_ID);
    addr_inc = (addr_q >= LAST_BANK) ? '0 : addr_q + 1'b1;
    rd_byte  = 8'h00;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (addr_q == (ADDR_MSB+1)'(b)) rd_byte = pin_sync_q[SYNC_STAGES-1][8*b +: 8];
    end
  end

  // Transaction FSM and register updates
  always_comb begin
    state_d   = state_q;
    is_addr_d = is_addr_q;
    addr_d    = addr_q;
    oea_d     = oea_q;
    autoinc_d = autoinc_q;
    sel_d     = sel_q;
    out_d     = out_q;
    oe_d      = oe_q;
    d_o_d     = d_o_q;
    d_oe_d    = d_oe_q;

    case (state_q)
      ST_IDLE: begin
        // Write has priority when both strobes fall together
        if (wr_fall_c) begin
          state_d   = ST_WR_ACT;
          is_addr_d = da_sync;
        end else if (rd_fall_c) begin
          state_d = ST_RD_ACT;
          if (sel_hit) begin
            d_o_d  = rd_byte;
            d_oe_d = 1'b1;
          end
        end
      end
      ST_WR_ACT: begin
        if (wr_rise_c) state_d = ST_WR_COMMIT;
      end
      ST_WR_COMMIT: begin
        state_d = ST_IDLE;
        if (is_addr_q) begin
          oea_d     = D_I[OEA_BIT];
          autoinc_d = D_I[AUTOINC_BIT];
          sel_d     = D_I[SEL_BIT];
          addr_d    = D_I[ADDR_MSB:0];
        end else begin
          if (sel_hit) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
              if (addr_q == (ADDR_MSB+1)'(b)) begin
                if (oea_q) oe_d[8*b +: 8] = D_I;
                else       out_d[8*b +: 8] = D_I;
              end
            end
          end
          if (autoinc_q) addr_d = addr_inc;
        end
      end
      ST_RD_ACT: begin
        if (rd_rise_c) begin
          state_d = ST_RD_DONE;
          d_oe_d  = 1'b0;
        end
      end
      ST_RD_DONE: begin
        state_d = ST_IDLE;
        if (autoinc_q) addr_d = addr_inc;
      end
      default: state_d = ST_IDLE;
    endcase

    rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge IFCLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      is_addr_q  <= 1'b0;
      addr_q     <= '0;
      oea_q      <= 1'b0;
      autoinc_q  <= 1'b0;
      sel_q      <= 1'b0;
      out_q      <= '0;
      oe_q       <= '0;
      d_o_q      <= 8'h00;
      d_oe_q     <= 1'b0;
      rdy_q      <= 1'b1;
      pin_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      is_addr_q  <= is_addr_d;
      addr_q     <= addr_d;
      oea_q      <= oea_d;
      autoinc_q  <= autoinc_d;
      sel_q      <= sel_d;
      out_q      <= out_d;
      oe_q       <= oe_d;
      d_o_q      <= d_o_d;
      d_oe_q     <= d_oe_d;
      rdy_q      <= rdy_d;
      pin_sync_q <= pin_sync_d;
    end
  end

  assign PINS_O  = out_q;
  assign PINS_OE = oe_q;
  assign D_O     = d_o_q;
  assign D_OE    = d_oe_q;
  assign RDY     = rdy_q;

endmodule

// File: tb/tb_pin_access_engine.sv
// Directed bench: three engine instances share the host bus.
//   A: NUM_BANKS=16, SEL_ID=0, SYNC_STAGES=2
//   B: NUM_BANKS=16, SEL_ID=1, SYNC_STAGES=2
//   C: NUM_BANKS=3,  SEL_ID=0, SYNC_STAGES=3 (out-of-range banks, wrap)
module tb_pin_access_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic n_rd = 1'b1, n_wr = 1'b1, n_d_a = 1'b1;
  logic [7:0] d_i = 8'h00;
  logic [127:0] pins_i = 128'h0;

  logic [7:0]   d_o_a, d_o_b, d_o_c;
  logic         d_oe_a, d_oe_b, d_oe_c;
  logic         rdy_a, rdy_b, rdy_c;
  logic [127:0] po_a, poe_a, po_b, poe_b;
  logic [23:0]  po_c, poe_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pin_access_engine #(.NUM_BANKS(16), .SEL_ID(1'b0), .SYNC_STAGES(2)) u_a (
    .IFCLK(clk), .RST(rst), .nRD(n_rd), .nWR(n_wr), .nD_A(n_d_a), .D_I(d_i),
    .D_O(d_o_a), .D_OE(d_oe_a), .RDY(rdy_a),
    .PINS_I(pins_i), .PINS_O(po_a), .PINS_OE(poe_a));

  pin_access_engine #(.NUM_BANKS(16), .SEL_ID(1'b1), .SYNC_STAGES(2)) u_b (
    .IFCLK(clk), .RST(rst), .nRD(n_rd), .nWR(n_wr), .nD_A(n_d_a), .D_I(d_i),
    .D_O(d_o_b), .D_OE(d_oe_b), .RDY(rdy_b),
    .PINS_I(pins_i), .PINS_O(po_b), .PINS_OE(poe_b));

  pin_access_engine #(.NUM_BANKS(3), .SEL_ID(1'b0), .SYNC_STAGES(3)) u_c (
    .IFCLK(clk), .RST(rst), .nRD(n_rd), .nWR(n_wr), .nD_A(n_d_a), .D_I(d_i),
    .D_O(d_o_c), .D_OE(d_oe_c), .RDY(rdy_c),
    .PINS_I(pins_i[23:0]), .PINS_O(po_c), .PINS_OE(poe_c));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for all instances to report idle
  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(rdy_a && rdy_b && rdy_c) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, {125'h0, rdy_a, rdy_b, rdy_c}, 128'h7);
  endtask

  task automatic host_write(input logic is_addr, input logic [7:0] data);
    @(negedge clk);
    n_d_a = is_addr;
    d_i   = data;
    repeat (4) @(negedge clk);
    n_wr = 1'b0;
    repeat (6) @(negedge clk);
    n_wr = 1'b1;
    repeat (10) @(negedge clk);
    wait_idle("wr_idle");
  endtask

  task automatic rd_low();
    @(negedge clk);
    n_rd = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic rd_high();
    n_rd = 1'b1;
    repeat (10) @(negedge clk);
    wait_idle("rd_idle");
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_oe_a", poe_a, 128'h0);
    check("rst_doe_a", {127'h0, d_oe_a}, 128'h0);
    check("rst_rdy_a", {127'h0, rdy_a}, 128'h1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_oe_a", poe_a, 128'h0);
    check("idle_o_a", po_a, 128'h0);
    check("idle_do_a", {120'h0, d_o_a}, 128'h0);
    check("idle_oe_b", poe_b, 128'h0);
    check("idle_rdy", {125'h0, rdy_a, rdy_b, rdy_c}, 128'h7);

    // Bank 3 enables then values on A
    host_write(1'b1, 8'h83);
    host_write(1'b0, 8'hF0);
    host_write(1'b1, 8'h03);
    host_write(1'b0, 8'hA5);
    check("wr_oe_a", poe_a, 128'h0000_0000_0000_0000_0000_0000_F000_0000);
    check("wr_o_a", po_a, 128'h0000_0000_0000_0000_0000_0000_A500_0000);
    check("wr_o_b", po_b, 128'h0);
    check("wr_o_c", {104'h0, po_c}, 128'h0);
    check("wr_oe_c", {104'h0, poe_c}, 128'h0);

    // Read bank 3: A sees pins, C is out of range and returns zero
    pins_i = 128'h2211_0000_0000_0000_0000_0000_5A00_0033;
    rd_low();
    check("rd3_do_a", {120'h0, d_o_a}, 128'h5A);
    check("rd3_doe_a", {127'h0, d_oe_a}, 128'h1);
    check("rd3_doe_b", {127'h0, d_oe_b}, 128'h0);
    check("rd3_do_c", {120'h0, d_o_c}, 128'h0);
    check("rd3_doe_c", {127'h0, d_oe_c}, 128'h1);
    rd_high();
    check("rd3_end_doe", {125'h0, d_oe_a, d_oe_b, d_oe_c}, 128'h0);

    // Autoinc from bank 4; on C addr 4 is dropped and wraps to bank 0
    host_write(1'b1, 8'h44);
    host_write(1'b0, 8'h77);
    host_write(1'b0, 8'h99);
    check("inc_o_a", po_a, 128'h0000_0000_0000_0000_0000_9977_A500_0000);
    check("inc_o_c", {104'h0, po_c}, 128'h0000_0099);
    check("inc_o_b", po_b, 128'h0);

    // B: autoinc reads across the wrap 14 -> 15 -> 0
    host_write(1'b1, 8'h5E);
    rd_low();
    check("rd14_do_b", {120'h0, d_o_b}, 128'h11);
    check("rd14_doe_b", {127'h0, d_oe_b}, 128'h1);
    check("rd14_doe_a", {127'h0, d_oe_a}, 128'h0);
    rd_high();
    rd_low();
    check("rd15_do_b", {120'h0, d_o_b}, 128'h22);
    check("rd15_doe_b", {127'h0, d_oe_b}, 128'h1);
    rd_high();
    rd_low();
    check("rd0_do_b", {120'h0, d_o_b}, 128'h33);
    check("rd0_doe_a", {127'h0, d_oe_a}, 128'h0);
    rd_high();
    check("rd0_end_doe_b", {127'h0, d_oe_b}, 128'h0);

    // Select 1 with data 0xFF: A and C must not change, B bank 0 does
    host_write(1'b1, 8'h10);
    host_write(1'b0, 8'hFF);
    check("sel_o_a", po_a, 128'h0000_0000_0000_0000_0000_9977_A500_0000);
    check("sel_oe_a", poe_a, 128'h0000_0000_0000_0000_0000_0000_F000_0000);
    check("sel_o_c", {104'h0, po_c}, 128'h0000_0099);
    check("sel_o_b", po_b, 128'hFF);
    rd_low();
    check("sel_rd_doe_a", {127'h0, d_oe_a}, 128'h0);
    check("sel_rd_doe_c", {127'h0, d_oe_c}, 128'h0);
    check("sel_rd_do_b", {120'h0, d_o_b}, 128'h33);
    rd_high();

    // nRD and nWR fall together: the write wins
    host_write(1'b1, 8'h02);
    @(negedge clk);
    n_d_a = 1'b0;
    d_i   = 8'h3C;
    repeat (4) @(negedge clk);
    n_wr = 1'b0;
    n_rd = 1'b0;
    repeat (6) @(negedge clk);
    check("sim_doe_a", {127'h0, d_oe_a}, 128'h0);
    check("sim_rdy_a", {127'h0, rdy_a}, 128'h0);
    n_wr = 1'b1;
    n_rd = 1'b1;
    repeat (10) @(negedge clk);
    wait_idle("sim_idle");
    check("sim_o_a", po_a, 128'h0000_0000_0000_0000_0000_9977_A53C_0000);
    check("sim_o_c", {104'h0, po_c}, 128'h003C_0099);
    check("sim_doe_all", {125'h0, d_oe_a, d_oe_b, d_oe_c}, 128'h0);

    // Reset in the middle of a read with bank 0 driven
    host_write(1'b1, 8'h80);
    host_write(1'b0, 8'hFF);
    check("oe0_a", poe_a, 128'h0000_0000_0000_0000_0000_0000_F000_00FF);
    host_write(1'b1, 8'h00);
    rd_low();
    check("rst_pre_doe_a", {127'h0, d_oe_a}, 128'h1);
    check("rst_pre_rdy_a", {127'h0, rdy_a}, 128'h0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_oe_a", poe_a, 128'h0);
    check("rst_mid_o_a", po_a, 128'h0);
    check("rst_mid_doe_a", {127'h0, d_oe_a}, 128'h0);
    check("rst_mid_rdy_a", {127'h0, rdy_a}, 128'h1);
    check("rst_mid_oe_c", {104'h0, poe_c}, 128'h0);
    @(negedge clk);
    n_rd = 1'b1;
    rst  = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_do_a", {120'h0, d_o_a}, 128'h0);
    check("post_rst_rdy", {125'h0, rdy_a, rdy_b, rdy_c}, 128'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pin_access_engine.md
Name: pin_access_engine

Overview:
- Synchronous, parametrised successor to the UP1024 direct-pin-access block.
- Host bus strobes (nRD, nWR, nD_A) are synchronised into one clock domain and decoded by a small FSM.
- Drives NUM_BANKS x 8 output/output-enable register banks and returns snapshotted pin values to the host.
- Adds address auto-increment, a compile-time chip-select ID (replaces the per-FPGA build switch), a RDY busy indication, and explicit tri-state control vectors. The top level builds the pads.

Parameters:
- NUM_BANKS, 16, number of 8-pin banks (1..16); pin count = 8*NUM_BANKS.
- SEL_ID, 0, value of the address-byte select bit that targets this instance (0 or 1).
- SYNC_STAGES, 2, synchroniser depth for strobes and pin inputs (>=2).

Ports:
- IFCLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- nRD  in  1  host read strobe, active low, asynchronous to IFCLK.
- nWR  in  1  host write strobe, active low, asynchronous.
- nD_A  in  1  sampled during write: 1 = address byte, 0 = data byte.
- D_I  in  8  host data bus input.
- D_O  out  8  host read data.
- D_OE  out  1  host data bus drive enable.
- RDY  out  1  1 = idle / ready for the next strobe.
- PINS_I  in  8*NUM_BANKS  pad input values.
- PINS_O  out  8*NUM_BANKS  pad output values.
- PINS_OE  out  8*NUM_BANKS  pad drive enables, per bit.

Behaviour:
- Reset, applied asynchronously:
  - addr=0, oea=0, sel=0, autoinc=0.
  - All outreg and oereg = 0, so PINS_OE=0 and every pin is hi-Z.
  - D_O=0, D_OE=0, RDY=1, FSM=IDLE.
- Synchronisation:
  - nRD, nWR, nD_A pass through SYNC_STAGES flops; falling and rising edges are detected on the synced copies.
  - PINS_I passes through SYNC_STAGES flops.
  - The host holds D_I and nD_A stable from nWR low until SYNC_STAGES+2 cycles after nWR high.
- Address byte (nD_A=1 on a write). On the synced nWR rising edge:
  - oea=D_I[7], autoinc=D_I[6], sel=D_I[4], addr=D_I[3:0].
  - D_I[5] is reserved and ignored.
- Data write (nD_A=0). Only acts if sel==SEL_ID and addr<NUM_BANKS:
  - oea=0: outreg[addr] = D_I.
  - oea=1: oereg[addr] = D_I.
  - If the select does not match, or addr>=NUM_BANKS, the write is dropped; addr still auto-increments if autoinc=1.
- Pins: PINS_O[8b+k] = outreg[b][k]; PINS_OE[8b+k] = oereg[b][k]. Both are registered, so there is no combinational path from D_I.
- Read:
  - On the synced nRD falling edge with sel==SEL_ID, D_O = synced pins of bank addr, snapshotted once. D_O = 0x00 if addr>=NUM_BANKS.
  - D_OE=1 from the cycle after the snapshot until the synced nRD rising edge, then 0 the same cycle.
  - If sel!=SEL_ID, D_OE stays 0.
- Auto-increment:
  - Applies after each data write or read completion when autoinc=1.
  - addr = (addr==NUM_BANKS-1) ? 0 : addr+1.
  - Addresses >= NUM_BANKS also wrap to 0.
- FSM states: IDLE, WR_ACT, WR_COMMIT, RD_ACT, RD_DONE.
  - IDLE -> WR_ACT on synced nWR fall. The nD_A value is latched at this point.
  - IDLE -> RD_ACT on synced nRD fall.
  - WR_ACT -> WR_COMMIT on synced nWR rise.
  - WR_COMMIT -> IDLE after one cycle. The register update happens in this cycle.
  - RD_ACT -> RD_DONE on synced nRD rise.
  - RD_DONE -> IDLE after one cycle. Auto-increment happens in this cycle.
  - RDY = 1 only in IDLE.
- Simultaneous nRD and nWR falling in the same cycle: write wins. The read is ignored until nRD rises and falls again.
- A strobe edge arriving while not in IDLE is ignored. Exception: the rise that completes the current phase.
- RST asserted mid-transaction returns every state to its reset value immediately. Pins go hi-Z.

Decomposition:
- pin_access_pkg:
  - FSM state enum.
  - Address-byte bit positions: OEA_BIT=7, AUTOINC_BIT=6, SEL_BIT=4, ADDR_MSB=3.
  - Constant MAX_BANKS=16.
- Sub-module strobe_sync: parametrised-depth synchroniser with rise/fall pulse outputs. Instantiated for nRD, nWR and nD_A.
- Pin-input synchroniser: a plain vector flop chain inside the top module.

Test Plan:
- Reset, then idle: PINS_OE=0, D_OE=0, RDY=1 for all 128 pins (NUM_BANKS=16).
- Address write 0x83, then data write 0xF0 (sel=0, SEL_ID=0), then address 0x03, data 0xA5 -> PINS_OE[31:24]=0xF0 and PINS_O[31:24]=0xA5; bits 27:24 of the pins are hi-Z.
- Address write 0x5E (autoinc, sel=1), SEL_ID=1, NUM_BANKS=16, three reads with PINS_I bank14=0x11, bank15=0x22, bank0=0x33 -> D_O sequence 0x11, 0x22, 0x33 (wrap), D_OE only while nRD is low.
- Instance with SEL_ID=0 receives address 0x10 and data 0xFF -> no register change; a read returns D_OE=0 throughout.
- nRD and nWR fall in the same cycle with a data write of 0x3C to bank 2 -> outreg[2]=0x3C, D_OE stays 0, RDY returns to 1 after WR_COMMIT.
- RST pulsed during RD_ACT with oereg[0]=0xFF -> PINS_OE=0, D_OE=0, RDY=1 within the same cycle, before the next IFCLK edge.
